fwd_writeback: RTL and testbench

Write-back and forwarding-source stage of the core. It sits after the ALU and the memory unit and is the producing end of the two `fwdregkv` forwarding buses, `onestep_forwarding` and `twostep_forwarding`, that the ALU consumes. It commits ALU and load results to the register file. It tracks the single outstanding load and exposes it as a hazard so issue logic can stall dependent instructions.

---
 rtl/def.sv | 19 +
 rtl/load_tracker.sv | 105 ++++++++++
 rtl/fwd_writeback.sv | 83 ++++++++
 tb/tb_fwd_writeback.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/def.sv
// Shared pipeline types and constants used across the core's stages.
package def;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // One forwarding entry: a committed register value visible to the ALU.
  typedef struct packed {
    logic             enabled;
    logic [REG_W-1:0] key;
    logic [XLEN-1:0]  value;
  } fwdregkv;

  // True when an instruction's result actually lands in the register file.
  function automatic logic writes_reg(input logic reg_write, input logic [REG_W-1:0] rd);
    return reg_write && (rd != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/load_tracker.sv
// Tracks the single outstanding memory response, flags protocol violations and
// tells the write-back stage when an exec or load result may be committed.
module load_tracker
  import def::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             exec_completed,
  input  logic [REG_W-1:0] exec_rd,
  input  logic             exec_reg_write,
  input  logic             exec_is_load,
  input  logic             mem_completed,
  output logic             exec_accept,
  output logic             load_commit,
  output logic             load_pending,
  output logic [REG_W-1:0] load_pending_key,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_DROP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [REG_W-1:0] key_nxt;
  logic             err_nxt;

  // Next-state, completion acceptance and protocol-violation decode
  always_comb begin
    state_nxt   = state;
    key_nxt     = load_pending_key;
    err_nxt     = proto_err;
    exec_accept = 1'b0;
    load_commit = 1'b0;
    case (state)
      IDLE: begin
        // No response is owed, so any data showing up is a violation.
        if (mem_completed) err_nxt = 1'b1;
        else               err_nxt = proto_err;
        if (exec_completed && !flush) begin
          if (!exec_is_load) begin
            exec_accept = 1'b1;
            state_nxt   = IDLE;
          end else if (writes_reg(exec_reg_write, exec_rd)) begin
            state_nxt = LOAD_WAIT;
            key_nxt   = exec_rd;
          end else begin
            // The response still arrives and must be swallowed.
            state_nxt = LOAD_DROP;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD_WAIT: begin
        // Issue must stall behind the pending load; any completion is illegal.
        if (exec_completed) err_nxt = 1'b1;
        else                err_nxt = proto_err;
        if (mem_completed) begin
          load_commit = !flush;
          state_nxt   = IDLE;
        end else if (flush) begin
          state_nxt = LOAD_DROP;
        end else begin
          state_nxt = LOAD_WAIT;
        end
      end
      LOAD_DROP: begin
        // Independent ALU work may retire, but a second load cannot issue.
        if (exec_completed && exec_is_load) begin
          err_nxt = 1'b1;
        end else if (exec_completed && !flush) begin
          exec_accept = 1'b1;
        end else begin
          exec_accept = 1'b0;
        end
        if (mem_completed) state_nxt = IDLE;
        else               state_nxt = LOAD_DROP;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pending-load key and sticky error registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      load_pending_key <= {REG_W{1'b0}};
      proto_err        <= 1'b0;
    end else begin
      state            <= state_nxt;
      load_pending_key <= key_nxt;
      proto_err        <= err_nxt;
    end
  end

  assign load_pending = (state == LOAD_WAIT);

endmodule

// File: rtl/fwd_writeback.sv
// Write-back stage: commits ALU and load results to the register file and
// drives the two-deep, newest-first forwarding history consumed by the ALU.
module fwd_writeback
  import def::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             exec_completed,
  input  logic [REG_W-1:0] exec_rd,
  input  logic             exec_reg_write,
  input  logic             exec_is_load,
  input  logic [XLEN-1:0]  exec_result,
  input  logic             mem_completed,
  input  logic [XLEN-1:0]  mem_data,
  output fwdregkv          onestep_forwarding,
  output fwdregkv          twostep_forwarding,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             load_pending,
  output logic [REG_W-1:0] load_pending_key,
  output logic             proto_err
);

  logic             exec_accept;
  logic             load_commit;
  logic             commit_valid;
  logic [REG_W-1:0] commit_key;
  logic [XLEN-1:0]  commit_value;

  load_tracker u_load_tracker (
    .clk              (clk),
    .rstn             (rstn),
    .flush            (flush),
    .exec_completed   (exec_completed),
    .exec_rd          (exec_rd),
    .exec_reg_write   (exec_reg_write),
    .exec_is_load     (exec_is_load),
    .mem_completed    (mem_completed),
    .exec_accept      (exec_accept),
    .load_commit      (load_commit),
    .load_pending     (load_pending),
    .load_pending_key (load_pending_key),
    .proto_err        (proto_err)
  );

  // Select the committing result; load and exec commits never coincide
  always_comb begin
    commit_valid = 1'b0;
    commit_key   = exec_rd;
    commit_value = exec_result;
    if (load_commit) begin
      commit_valid = 1'b1;
      commit_key   = load_pending_key;
      commit_value = mem_data;
    end else begin
      commit_valid = exec_accept && writes_reg(exec_reg_write, exec_rd);
      commit_key   = exec_rd;
      commit_value = exec_result;
    end
  end

  // Shift the forwarding history and pulse the register-file write per commit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      onestep_forwarding <= '0;
      twostep_forwarding <= '0;
      rf_we              <= 1'b0;
      rf_waddr           <= {REG_W{1'b0}};
      rf_wdata           <= {XLEN{1'b0}};
    end else if (commit_valid) begin
      twostep_forwarding <= onestep_forwarding;
      onestep_forwarding <= '{enabled: 1'b1, key: commit_key, value: commit_value};
      rf_we              <= 1'b1;
      rf_waddr           <= commit_key;
      rf_wdata           <= commit_value;
    end else begin
      rf_we              <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fwd_writeback.sv
// Self-checking bench for fwd_writeback: directed scenarios followed by random
// traffic, compared each cycle against a queue-based reference model.
module tb_fwd_writeback;
  import def::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        exec_completed = 1'b0;
  logic [4:0]  exec_rd = 5'd0;
  logic        exec_reg_write = 1'b0;
  logic        exec_is_load = 1'b0;
  logic [31:0] exec_result = 32'd0;
  logic        mem_completed = 1'b0;
  logic [31:0] mem_data = 32'd0;
  fwdregkv     onestep_forwarding;
  fwdregkv     twostep_forwarding;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_pending;
  logic [4:0]  load_pending_key;
  logic        proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: committed history (newest at index 0) plus the owed load.
  fwdregkv     hist[$];
  bit          m_owed;
  bit          m_want;
  logic [4:0]  m_key;
  bit          m_perr;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  fwd_writeback dut (
    .clk                (clk),
    .rstn               (rstn),
    .flush              (flush),
    .exec_completed     (exec_completed),
    .exec_rd            (exec_rd),
    .exec_reg_write     (exec_reg_write),
    .exec_is_load       (exec_is_load),
    .exec_result        (exec_result),
    .mem_completed      (mem_completed),
    .mem_data           (mem_data),
    .onestep_forwarding (onestep_forwarding),
    .twostep_forwarding (twostep_forwarding),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .load_pending       (load_pending),
    .load_pending_key   (load_pending_key),
    .proto_err          (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic fwdregkv exp_fwd(input int idx);
    fwdregkv e;
    e = '0;
    if (hist.size() > idx) e = hist[idx];
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_owed = 0; m_want = 0; m_key = 5'd0; m_perr = 0;
    m_we = 0; m_waddr = 5'd0; m_wdata = 32'd0;
  endtask

  task automatic model_commit(input logic [4:0] k, input logic [31:0] v);
    fwdregkv e;
    e.enabled = 1'b1; e.key = k; e.value = v;
    hist.push_front(e);
    if (hist.size() > 2) void'(hist.pop_back());
    m_we = 1; m_waddr = k; m_wdata = v;
  endtask

  // Apply one clock edge's worth of the write-back rules to the model.
  task automatic model_clock();
    bit was_owed, violation, accept;
    was_owed = m_owed;
    m_we = 0;
    violation = exec_completed && was_owed && (m_want || exec_is_load);
    accept = exec_completed && !flush && !exec_is_load && !(was_owed && m_want);
    if (violation) m_perr = 1;
    if (mem_completed && !was_owed) m_perr = 1;
    if (accept && exec_reg_write && exec_rd != 5'd0) model_commit(exec_rd, exec_result);
    if (was_owed) begin
      if (mem_completed) begin
        if (m_want && !flush) model_commit(m_key, mem_data);
        m_owed = 0; m_want = 0;
      end else if (flush) begin
        m_want = 0;
      end
    end else if (exec_completed && !flush && exec_is_load) begin
      m_owed = 1;
      m_want = exec_reg_write && exec_rd != 5'd0;
      if (m_want) m_key = exec_rd;
    end
  endtask

  task automatic compare_all();
    check_eq("onestep", onestep_forwarding, exp_fwd(0));
    check_eq("twostep", twostep_forwarding, exp_fwd(1));
    check_eq("rf_we", rf_we, m_we);
    check_eq("rf_waddr", rf_waddr, m_waddr);
    check_eq("rf_wdata", rf_wdata, m_wdata);
    check_eq("load_pending", load_pending, m_owed && m_want);
    if (m_owed && m_want) check_eq("load_pending_key", load_pending_key, m_key);
    check_eq("proto_err", proto_err, m_perr);
  endtask

  task automatic clear_inputs();
    flush = 0; exec_completed = 0; exec_rd = 5'd0; exec_reg_write = 0;
    exec_is_load = 0; exec_result = 32'd0; mem_completed = 0; mem_data = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
    clear_inputs();
  endtask

  task automatic exec_op(input logic [4:0] rd, input logic rw, input logic ld, input logic [31:0] res);
    exec_completed = 1; exec_rd = rd; exec_reg_write = rw; exec_is_load = ld; exec_result = res;
    tick();
  endtask

  task automatic mem_op(input logic [31:0] d);
    mem_completed = 1; mem_data = d;
    tick();
  endtask

  task automatic apply_reset();
    rstn = 0;
    model_reset();
    @(posedge clk);
    #1 rstn = 1;
    compare_all();
  endtask

  initial begin
    model_reset();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    compare_all();

    // Two commits build a newest-first history.
    exec_op(5'd5, 1'b1, 1'b0, 32'h10);
    check_eq("plan1_one", onestep_forwarding, {1'b1, 5'd5, 32'h10});
    check_eq("plan1_we", rf_we, 1'b1);
    exec_op(5'd6, 1'b1, 1'b0, 32'h20);
    check_eq("plan1_two", twostep_forwarding, {1'b1, 5'd5, 32'h10});
    tick();

    // Non-commit completions: store and rd = 0.
    exec_op(5'd9, 1'b0, 1'b0, 32'h77);
    exec_op(5'd0, 1'b1, 1'b0, 32'hFFFF);
    check_eq("plan2_one", onestep_forwarding, {1'b1, 5'd6, 32'h20});

    // Load to rd 7 with data three cycles later.
    exec_op(5'd7, 1'b1, 1'b1, 32'h4000);
    check_eq("plan3_pend", load_pending, 1'b1);
    check_eq("plan3_key", load_pending_key, 5'd7);
    tick(); tick();
    mem_op(32'hDEADBEEF);
    check_eq("plan3_one", onestep_forwarding, {1'b1, 5'd7, 32'hDEADBEEF});
    check_eq("plan3_pend_lo", load_pending, 1'b0);

    // Flush while waiting, ALU op retires in LOAD_DROP, late data dropped.
    exec_op(5'd8, 1'b1, 1'b1, 32'h0);
    flush = 1; tick();
    check_eq("plan4_pend", load_pending, 1'b0);
    exec_op(5'd3, 1'b1, 1'b0, 32'h5);
    check_eq("plan4_one", onestep_forwarding, {1'b1, 5'd3, 32'h5});
    mem_op(32'h1234);
    check_eq("plan4_nowe", rf_we, 1'b0);
    exec_op(5'd4, 1'b1, 1'b0, 32'h44);

    // Completion during LOAD_WAIT is a violation and does not shift.
    exec_op(5'd9, 1'b1, 1'b1, 32'h0);
    exec_op(5'd10, 1'b1, 1'b0, 32'hAA);
    check_eq("plan5_err", proto_err, 1'b1);
    mem_op(32'h99);
    tick();

    // Clear the error, then async reset mid-LOAD_WAIT with live history.
    apply_reset();
    exec_op(5'd11, 1'b1, 1'b0, 32'h1111);
    exec_op(5'd12, 1'b1, 1'b1, 32'h0);
    #3 rstn = 0;
    #1;
    check_eq("rst_one", onestep_forwarding, 38'd0);
    check_eq("rst_two", twostep_forwarding, 38'd0);
    check_eq("rst_we", rf_we, 1'b0);
    check_eq("rst_waddr", rf_waddr, 5'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_pend", load_pending, 1'b0);
    check_eq("rst_key", load_pending_key, 5'd0);
    check_eq("rst_err", proto_err, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rstn = 1;
    compare_all();
    mem_op(32'h5555);
    check_eq("idle_mem_err", proto_err, 1'b1);

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) apply_reset();
      exec_completed = ($urandom_range(0, 9) < 4);
      exec_is_load   = ($urandom_range(0, 9) < 3);
      exec_reg_write = ($urandom_range(0, 9) < 8);
      exec_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      exec_result    = $urandom;
      flush          = ($urandom_range(0, 9) == 0);
      mem_completed  = m_owed ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      mem_data       = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
